mvu_act_buffer: RTL
===================

Name: mvu_act_buffer

Overview:
- Input activation buffer directly upstream of the PE array in the matrix-vector unit.
- Accepts one input vector as SF = MatrixW/SIMD stream words of SIMD*TSrcI bits and forwards each word to the PEs while storing it.
- Replays the stored vector NF = MatrixH/PE times in total, with fold markers, so each PE accumulator knows when a row dot-product completes.

Parameters:
- SIMD, 2, activation elements per stream word (matches PE SIMD width)
- PE, 2, processing elements fed in parallel
- TSrcI, 4, bits per activation element
- MatrixW, 8, matrix columns; must be a multiple of SIMD; SF = MatrixW/SIMD >= 1
- MatrixH, 6, matrix rows; must be a multiple of PE; NF = MatrixH/PE >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_v  in  1  upstream word valid
- in_rdy  out  1  buffer can accept a word
- in_act  in  SIMD*TSrcI  upstream activation word; element i at bits [i*TSrcI +: TSrcI]
- out_v  out  1  activation word valid to PEs
- out_rdy  in  1  PE array accepts the word
- out_act  out  SIMD*TSrcI  activation word to PEs (same packing as in_act)
- sf_last  out  1  out_act is fold SF-1 of the current row pass (accumulator emit/clear marker)
- nf_last  out  1  current pass is the last (NF-1) replay of this vector

Behaviour:
- Storage: SF entries x SIMD*TSrcI flops, asynchronous read. Contents are not cleared by rst.
- Counters:
  - sf_cnt in 0..SF-1 and nf_cnt in 0..NF-1, both reset to 0.
  - An output handshake (out_v & out_rdy) increments sf_cnt.
  - When sf_cnt = SF-1 and a handshake occurs, sf_cnt wraps to 0 and nf_cnt increments.
  - nf_cnt wraps to 0 after NF-1.
- State WRITE (reset state, nf_cnt = 0): pass-through with zero latency.
  - out_v = in_v, in_rdy = out_rdy, out_act = in_act.
  - On handshake, store in_act into entry sf_cnt.
  - On the handshake with sf_cnt = SF-1: go to READ if NF > 1; stay in WRITE if NF = 1.
- State READ (nf_cnt >= 1):
  - in_rdy = 0, out_v = 1, out_act = entry[sf_cnt].
  - On the handshake with sf_cnt = SF-1 and nf_cnt = NF-1: go to WRITE with both counters at 0.
- Markers are combinational from the counters:
  - sf_last = (sf_cnt == SF-1)
  - nf_last = (nf_cnt == NF-1)
  - Both are meaningful only while out_v = 1.
- Backpressure:
  - out_rdy = 0 holds out_act, sf_last, nf_last and the counters stable.
  - In WRITE, out_v follows in_v, so upstream must hold in_act while stalled (AXI-stream rule).
- Reset outputs:
  - While rst = 1, force in_rdy = 0 and out_v = 0.
  - After release, the buffer is in WRITE with counters at 0.
  - Reset mid-pass abandons the vector; the next accepted word is treated as fold 0 of pass 0.
- Boundaries:
  - SF = 1: every word is sf_last.
  - NF = 1: the block is a pure pass-through with nf_last = 1 always.
  - SF = 1 and NF = 1: both markers are constant 1.
- Elaboration checks: assert MatrixW % SIMD == 0 and MatrixH % PE == 0.
- Throughput: one word per cycle when out_rdy = 1. Total SF*NF output beats per vector; no bubble between passes or between vectors (WRITE of the next vector can start in the cycle after the final READ handshake).

Test Plan:
- Basic replay (defaults, SF=4, NF=3), out_rdy held 1: feed words 0x11,0x22,0x33,0x44.
  - Output sequence is 0x11,0x22,0x33,0x44 three times, 12 beats on consecutive cycles.
  - sf_last high on beats 4, 8, 12; nf_last high on beats 9-12.
  - in_rdy is low on the 8 READ cycles.
- Backpressure: drop out_rdy for 3 cycles at pass 1, word 2.
  - out_act stays 0x33 and sf_last/nf_last stay stable.
  - Sequence resumes without loss or duplication.
- Upstream gaps in WRITE: in_v low for 2 cycles between words 1 and 2.
  - out_v mirrors in_v, nothing is stored during the gap, sf_cnt does not advance.
- Back-to-back vectors: present the second vector 0xA1..0xA4 on in_v throughout.
  - in_rdy rises on the cycle after beat 12.
  - Beat 13 outputs 0xA1 with nf_last = 0.
- Reset mid-operation: assert rst during pass 1, word 3, then feed 0x55..0x88.
  - out_v = 0 and in_rdy = 0 during rst.
  - After release, the output is 0x55,0x66,0x77,0x88 x3, with no stale 0x11..0x44 beats.
- Degenerate NF=1, SF=1 (MatrixW=2, MatrixH=2): any word passes through same-cycle, with sf_last = nf_last = 1 on every beat.

Source files
------------

// File: rtl/mvu_act_buffer_if.sv
// Activation stream interface of mvu_act_buffer: upstream word input and PE-side word output.
// The master is the environment (upstream + PE array); the slave is the buffer.
interface mvu_act_buffer_if #(
    parameter int unsigned W = 8
);
    logic         in_v;
    logic         in_rdy;
    logic [W-1:0] in_act;
    logic         out_v;
    logic         out_rdy;
    logic [W-1:0] out_act;
    logic         sf_last;
    logic         nf_last;

    modport master (
        output in_v, in_act, out_rdy,
        input  in_rdy, out_v, out_act, sf_last, nf_last
    );

    modport slave (
        input  in_v, in_act, out_rdy,
        output in_rdy, out_v, out_act, sf_last, nf_last
    );
endinterface

// File: rtl/mvu_act_buffer.sv
// Input activation buffer for the MVU PE array: passes the first pass of a vector straight
// through while storing it, then replays it NF-1 more times with fold markers.
module mvu_act_buffer #(
    parameter int unsigned SIMD    = 2,
    parameter int unsigned PE      = 2,
    parameter int unsigned TSrcI   = 4,
    parameter int unsigned MatrixW = 8,
    parameter int unsigned MatrixH = 6
) (
    input  logic                clk,
    input  logic                rst,
    mvu_act_buffer_if.slave     bus
);
    localparam int unsigned W    = SIMD * TSrcI;
    localparam int unsigned SF   = MatrixW / SIMD;
    localparam int unsigned NF   = MatrixH / PE;
    localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;

    if ((MatrixW % SIMD) != 0 || MatrixW < SIMD) begin : g_bad_matrix_w
        $error("mvu_act_buffer: MatrixW must be a non-zero multiple of SIMD");
    end
    if ((MatrixH % PE) != 0 || MatrixH < PE) begin : g_bad_matrix_h
        $error("mvu_act_buffer: MatrixH must be a non-zero multiple of PE");
    end

    typedef enum logic {
        S_WRITE = 1'b0,
        S_READ  = 1'b1
    } state_t;

    state_t            state;
    logic [SF_W-1:0]   sf_cnt;
    logic [NF_W-1:0]   nf_cnt;
    logic [W-1:0]      mem [SF];
    logic              at_sf_end;
    logic              at_nf_end;
    logic              hs;

    assign at_sf_end = (sf_cnt == SF_W'(SF - 1));
    assign at_nf_end = (nf_cnt == NF_W'(NF - 1));
    assign hs        = bus.out_v & bus.out_rdy;

    // Output steering: zero-latency pass-through while writing, stored replay while reading
    always_comb begin
        bus.out_v   = 1'b0;
        bus.in_rdy  = 1'b0;
        bus.out_act = bus.in_act;
        bus.sf_last = at_sf_end;
        bus.nf_last = at_nf_end;
        if (state == S_WRITE) begin
            bus.out_v  = bus.in_v & ~rst;
            bus.in_rdy = bus.out_rdy & ~rst;
        end else begin
            bus.out_v   = ~rst;
            bus.out_act = mem[sf_cnt];
        end
    end

    // Fold counters and pass state; a handshake on the last fold of the last pass rearms WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_WRITE;
            sf_cnt <= '0;
            nf_cnt <= '0;
        end else if (hs) begin
            if (at_sf_end) begin
                sf_cnt <= '0;
                if (at_nf_end) begin
                    nf_cnt <= '0;
                    state  <= S_WRITE;
                end else begin
                    nf_cnt <= nf_cnt + NF_W'(1);
                    state  <= S_READ;
                end
            end else begin
                sf_cnt <= sf_cnt + SF_W'(1);
            end
        end
    end

    // Vector storage is not reset; every entry is rewritten before it is replayed
    always_ff @(posedge clk) begin
        if (state == S_WRITE && hs) begin
            mem[sf_cnt] <= bus.in_act;
        end
    end
endmodule
